// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: opcodes, funct3 encodings,
// FSM states and the access-size decode.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } lsu_state_e;

    // Access size in bytes; the low two funct3 bits encode it for every legal op.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic       rv64);
        logic ok;
        ok = 1'b0;
        if (opcode == OP_LOAD) begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = rv64;
                default:                        ok = 1'b0;
            endcase
        end else if (opcode == OP_STORE) begin
            case (funct3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = rv64;
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Extracts the addressed bytes from the two captured read beats and
// sign- or zero-extends them to XLEN according to funct3.
module load_data_aligner
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          i_raw,
    input  logic [$clog2(XLEN/8)-1:0]  i_offset,
    input  logic [2:0]                 i_funct3,
    output logic [XLEN-1:0]            o_data
);

    logic [XLEN-1:0] w_bytes;

    // Beat 1 sits above beat 0, so a plain right shift assembles little-endian.
    assign w_bytes = XLEN'(i_raw >> {i_offset, 3'b000});

    always_comb begin
        // NOTE: o_data gets a default before the case so no path can infer a latch.
        o_data = w_bytes;
        case (i_funct3)
            F3_B:    o_data = XLEN'($signed(w_bytes[7:0]));
            F3_H:    o_data = XLEN'($signed(w_bytes[15:0]));
            F3_W:    o_data = XLEN'($signed(w_bytes[31:0]));
            F3_BU:   o_data = XLEN'(w_bytes[7:0]);
            F3_HU:   o_data = XLEN'(w_bytes[15:0]);
            F3_WU:   o_data = XLEN'(w_bytes[31:0]);
            default: o_data = w_bytes;
        endcase
    end

endmodule

// File: rtl/load_store_controller.sv
// Single-outstanding load/store unit: decodes a core request, issues one or two
// aligned memory beats, and returns an extended load result or a fault.
module load_store_controller
    import lsu_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     address,
    input  logic [XLEN-1:0]     store_data,
    output logic                resp_valid,
    output logic [XLEN-1:0]     load_data,
    output logic                misaligned_fault,
    output logic                access_fault,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_write,
    output logic [XLEN-1:0]     mem_address,
    output logic [XLEN-1:0]     mem_write_data,
    output logic [XLEN/8-1:0]   mem_byte_mask,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_read_data
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int MW    = 2 * NB;

    lsu_state_e         r_state;
    lsu_state_e         w_state_next;
    logic               r_beat;
    logic               r_split;
    logic               r_access_fault;
    logic               r_misaligned_fault;
    logic [6:0]         r_opcode;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_address;
    logic [XLEN-1:0]    r_store_data;
    logic [XLEN-1:0]    r_rdata_lo;
    logic [XLEN-1:0]    r_rdata_hi;

    logic               w_accept;
    logic               w_capture;
    logic               w_next_beat;

    // Request decode, evaluated on the raw inputs while IDLE.
    logic [OFF_W-1:0]   w_req_offset;
    logic [4:0]         w_req_end;
    logic               w_req_cross;
    logic               w_req_legal;
    logic               w_req_reject;

    assign w_req_offset = address[OFF_W-1:0];
    assign w_req_end    = 5'(w_req_offset) + 5'(size_bytes(funct3));
    assign w_req_cross  = (w_req_end > 5'(NB));
    assign w_req_legal  = is_legal(opcode, funct3, XLEN == 64);
    assign w_req_reject = !w_req_legal || (w_req_cross && (SUPPORT_MISALIGNED == 0));

    // Beat geometry from the registered request; lanes past XLEN/8 spill into beat 1.
    logic [OFF_W-1:0]   w_offset;
    logic [MW-1:0]      w_mask_wide;
    logic [2*XLEN-1:0]  w_data_wide;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_aligned_load;

    assign w_offset    = r_address[OFF_W-1:0];
    assign w_mask_wide = MW'((16'd1 << size_bytes(r_funct3)) - 16'd1) << w_offset;
    assign w_data_wide = {{XLEN{1'b0}}, r_store_data} << {w_offset, 3'b000};
    assign w_base      = {r_address[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    load_data_aligner #(
        .XLEN (XLEN)
    ) u_aligner (
        .i_raw    ({r_rdata_hi, r_rdata_lo}),
        .i_offset (w_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned_load)
    );

    always_ff @(posedge CLK) begin
        // NOTE: reset is sampled on the clock edge; all sequential state uses <=.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_accept         = 1'b0;
        w_capture        = 1'b0;
        w_next_beat      = 1'b0;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        load_data        = '0;
        misaligned_fault = 1'b0;
        access_fault     = 1'b0;
        mem_req_valid    = 1'b0;
        mem_write        = 1'b0;
        mem_byte_mask    = '0;
        mem_address      = r_beat ? (w_base + XLEN'(NB)) : w_base;
        mem_write_data   = r_beat ? w_data_wide[2*XLEN-1:XLEN] : w_data_wide[XLEN-1:0];

        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_req_reject ? ST_RESPOND : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_write     = (r_opcode == OP_STORE);
                mem_byte_mask = r_beat ? w_mask_wide[MW-1:NB] : w_mask_wide[NB-1:0];
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_capture = 1'b1;
                    if (r_split && !r_beat) begin
                        w_next_beat  = 1'b1;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_state_next = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                resp_valid       = 1'b1;
                misaligned_fault = r_misaligned_fault;
                access_fault     = r_access_fault;
                if ((r_opcode == OP_LOAD) && !r_access_fault && !r_misaligned_fault) begin
                    load_data = w_aligned_load;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet for the whole reset window, including the
        // first cycle before the state register has been cleared.
        if (reset) begin
            req_ready        = 1'b0;
            resp_valid       = 1'b0;
            load_data        = '0;
            misaligned_fault = 1'b0;
            access_fault     = 1'b0;
            mem_req_valid    = 1'b0;
            mem_write        = 1'b0;
            mem_byte_mask    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_beat             <= 1'b0;
            r_split            <= 1'b0;
            r_access_fault     <= 1'b0;
            r_misaligned_fault <= 1'b0;
            r_opcode           <= '0;
            r_funct3           <= '0;
            r_address          <= '0;
            r_store_data       <= '0;
            r_rdata_lo         <= '0;
            r_rdata_hi         <= '0;
        end else begin
            if (w_accept) begin
                r_opcode           <= opcode;
                r_funct3           <= funct3;
                r_address          <= address;
                r_store_data       <= store_data;
                r_split            <= w_req_cross;
                r_access_fault     <= !w_req_legal;
                r_misaligned_fault <= w_req_legal && w_req_cross && (SUPPORT_MISALIGNED == 0);
                r_beat             <= 1'b0;
            end
            if (w_capture) begin
                if (r_beat) begin
                    r_rdata_hi <= mem_read_data;
                end else begin
                    r_rdata_lo <= mem_read_data;
                end
            end
            if (w_next_beat) begin
                r_beat <= 1'b1;
            end
            if (r_state == ST_RESPOND) begin
                r_beat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench: three controller instances (32-bit split, 32-bit faulting,
// 64-bit) share stimulus; a selector picks which one is observed.
module tb_load_store_controller;
    import lsu_pkg::*;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset;
    logic [2:0]  req_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] address;
    logic [63:0] store_data;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_read_data;

    logic        a_req_ready, a_resp_valid, a_mf, a_af, a_mem_req_valid, a_mem_write;
    logic [31:0] a_load_data, a_mem_address, a_mem_write_data;
    logic [3:0]  a_mem_byte_mask;
    logic        b_req_ready, b_resp_valid, b_mf, b_af, b_mem_req_valid, b_mem_write;
    logic [31:0] b_load_data, b_mem_address, b_mem_write_data;
    logic [3:0]  b_mem_byte_mask;
    logic        c_req_ready, c_resp_valid, c_mf, c_af, c_mem_req_valid, c_mem_write;
    logic [63:0] c_load_data, c_mem_address, c_mem_write_data;
    logic [7:0]  c_mem_byte_mask;

    load_store_controller #(.XLEN(32), .SUPPORT_MISALIGNED(1)) u_dut_a (
        .CLK(CLK), .reset(reset), .req_valid(req_valid[0]), .req_ready(a_req_ready),
        .opcode(opcode), .funct3(funct3), .address(address[31:0]), .store_data(store_data[31:0]),
        .resp_valid(a_resp_valid), .load_data(a_load_data), .misaligned_fault(a_mf), .access_fault(a_af),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(a_mem_write),
        .mem_address(a_mem_address), .mem_write_data(a_mem_write_data), .mem_byte_mask(a_mem_byte_mask),
        .mem_resp_valid(mem_resp_valid), .mem_read_data(mem_read_data[31:0])
    );

    load_store_controller #(.XLEN(32), .SUPPORT_MISALIGNED(0)) u_dut_b (
        .CLK(CLK), .reset(reset), .req_valid(req_valid[1]), .req_ready(b_req_ready),
        .opcode(opcode), .funct3(funct3), .address(address[31:0]), .store_data(store_data[31:0]),
        .resp_valid(b_resp_valid), .load_data(b_load_data), .misaligned_fault(b_mf), .access_fault(b_af),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(b_mem_write),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data), .mem_byte_mask(b_mem_byte_mask),
        .mem_resp_valid(mem_resp_valid), .mem_read_data(mem_read_data[31:0])
    );

    load_store_controller #(.XLEN(64), .SUPPORT_MISALIGNED(1)) u_dut_c (
        .CLK(CLK), .reset(reset), .req_valid(req_valid[2]), .req_ready(c_req_ready),
        .opcode(opcode), .funct3(funct3), .address(address), .store_data(store_data),
        .resp_valid(c_resp_valid), .load_data(c_load_data), .misaligned_fault(c_mf), .access_fault(c_af),
        .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(c_mem_write),
        .mem_address(c_mem_address), .mem_write_data(c_mem_write_data), .mem_byte_mask(c_mem_byte_mask),
        .mem_resp_valid(mem_resp_valid), .mem_read_data(mem_read_data)
    );

    int          sel;
    logic        obs_req_ready, obs_resp_valid, obs_mf, obs_af, obs_mem_req_valid, obs_mem_write;
    logic [63:0] obs_load_data, obs_mem_address, obs_mem_write_data;
    logic [7:0]  obs_mem_byte_mask;

    always_comb begin
        obs_req_ready      = c_req_ready;
        obs_resp_valid     = c_resp_valid;
        obs_mf             = c_mf;
        obs_af             = c_af;
        obs_mem_req_valid  = c_mem_req_valid;
        obs_mem_write      = c_mem_write;
        obs_load_data      = c_load_data;
        obs_mem_address    = c_mem_address;
        obs_mem_write_data = c_mem_write_data;
        obs_mem_byte_mask  = c_mem_byte_mask;
        if (sel == 0) begin
            obs_req_ready      = a_req_ready;
            obs_resp_valid     = a_resp_valid;
            obs_mf             = a_mf;
            obs_af             = a_af;
            obs_mem_req_valid  = a_mem_req_valid;
            obs_mem_write      = a_mem_write;
            obs_load_data      = 64'(a_load_data);
            obs_mem_address    = 64'(a_mem_address);
            obs_mem_write_data = 64'(a_mem_write_data);
            obs_mem_byte_mask  = 8'(a_mem_byte_mask);
        end else if (sel == 1) begin
            obs_req_ready      = b_req_ready;
            obs_resp_valid     = b_resp_valid;
            obs_mf             = b_mf;
            obs_af             = b_af;
            obs_mem_req_valid  = b_mem_req_valid;
            obs_mem_write      = b_mem_write;
            obs_load_data      = 64'(b_load_data);
            obs_mem_address    = 64'(b_mem_address);
            obs_mem_write_data = 64'(b_mem_write_data);
            obs_mem_byte_mask  = 8'(b_mem_byte_mask);
        end
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int          res_latency;
    int          res_beats;
    logic [63:0] res_data;
    logic        res_mf, res_af;
    logic [63:0] beat_addr [2];
    logic [63:0] beat_mask [2];
    logic [63:0] beat_wdata[2];
    logic        beat_write[2];

    // Drives one request into the selected instance and plays a memory that
    // answers one cycle after each accepted beat, holding ready low for
    // rdy_delay cycles of every beat.
    task automatic do_access(input int dut, input logic [6:0] op, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] sdata,
                             input int rdy_delay, input logic [63:0] rd0, input logic [63:0] rd1);
        int          cyc;
        int          stall;
        bit          pending;
        bit          done;
        logic [63:0] first_addr, first_mask, first_wdata;
        sel        = dut;
        opcode     = op;
        funct3     = f3;
        address    = addr;
        store_data = sdata;
        req_valid  = 3'b000;
        req_valid[dut] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            beat_addr[i]  = '1;
            beat_mask[i]  = '1;
            beat_wdata[i] = '1;
            beat_write[i] = 1'bx;
        end
        #1;
        check("accept_ready", obs_req_ready, 1'b1);
        tick();
        req_valid   = 3'b000;
        cyc         = 0;
        stall       = 0;
        pending     = 0;
        done        = 0;
        res_beats   = 0;
        res_latency = 0;
        first_addr  = '0;
        first_mask  = '0;
        first_wdata = '0;
        while (!done && cyc < 40) begin
            cyc++;
            mem_resp_valid = pending;
            if (pending) mem_read_data = (res_beats == 1) ? rd0 : rd1;
            pending       = 0;
            mem_req_ready = 1'b0;
            if (obs_resp_valid) begin
                done        = 1;
                res_latency = cyc;
                res_data    = obs_load_data;
                res_mf      = obs_mf;
                res_af      = obs_af;
            end else if (obs_mem_req_valid) begin
                if (stall == 0) begin
                    first_addr  = obs_mem_address;
                    first_mask  = 64'(obs_mem_byte_mask);
                    first_wdata = obs_mem_write_data;
                end else begin
                    check("stable_addr", obs_mem_address, first_addr);
                    check("stable_mask", 64'(obs_mem_byte_mask), first_mask);
                    check("stable_wdata", obs_mem_write_data, first_wdata);
                end
                if (stall >= rdy_delay) begin
                    mem_req_ready = 1'b1;
                    pending       = 1;
                    stall         = 0;
                    if (res_beats < 2) begin
                        beat_addr[res_beats]  = obs_mem_address;
                        beat_mask[res_beats]  = 64'(obs_mem_byte_mask);
                        beat_wdata[res_beats] = obs_mem_write_data;
                        beat_write[res_beats] = obs_mem_write;
                    end
                    res_beats++;
                end else begin
                    stall++;
                end
            end
            if (!done) tick();
        end
        check("resp_seen", done, 1'b1);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        tick();
        check("resp_one_cycle", obs_resp_valid, 1'b0);
        check("ready_after_resp", obs_req_ready, 1'b1);
    endtask

    task automatic check_resp(input string t, input int lat, input int beats,
                              input logic [63:0] data, input logic mf, input logic af);
        check({t, "_latency"}, 64'(res_latency), 64'(lat));
        check({t, "_beats"}, 64'(res_beats), 64'(beats));
        check({t, "_data"}, res_data, data);
        check({t, "_misaligned"}, res_mf, mf);
        check({t, "_access"}, res_af, af);
    endtask

    task automatic check_beat(input string t, input int i, input logic [63:0] addr,
                              input logic [63:0] mask, input logic wr);
        check({t, "_addr"}, beat_addr[i], addr);
        check({t, "_mask"}, beat_mask[i], mask);
        check({t, "_write"}, beat_write[i], wr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        req_valid      = 3'b000;
        opcode         = '0;
        funct3         = '0;
        address        = '0;
        store_data     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_read_data  = '0;
        sel            = 0;
        #1;
        check("rst_req_ready", obs_req_ready, 1'b0);
        check("rst_resp_valid", obs_resp_valid, 1'b0);
        check("rst_mem_req_valid", obs_mem_req_valid, 1'b0);
        check("rst_mem_write", obs_mem_write, 1'b0);
        check("rst_mask", 64'(obs_mem_byte_mask), 64'h0);
        check("rst_load_data", obs_load_data, 64'h0);
        check("rst_faults", {obs_mf, obs_af}, 2'b00);
        tick();
        tick();
        sel = 2;
        #1;
        check("rst64_req_ready", obs_req_ready, 1'b0);
        check("rst64_mask", 64'(obs_mem_byte_mask), 64'h0);
        reset = 1'b0;
        #1;
        check("idle64_req_ready", obs_req_ready, 1'b1);
        sel = 0;
        #1;
        check("idle32_req_ready", obs_req_ready, 1'b1);

        // 32-bit, split accesses enabled
        do_access(0, OP_LOAD, F3_W, 64'h100, 64'h0, 0, 64'h8000_00F0, 64'h0);
        check_resp("lw", 3, 1, 64'h8000_00F0, 1'b0, 1'b0);
        check_beat("lw_b0", 0, 64'h100, 64'hF, 1'b0);

        do_access(0, OP_LOAD, F3_B, 64'h103, 64'h0, 0, 64'h9A00_0000, 64'h0);
        check_resp("lb", 3, 1, 64'hFFFF_FF9A, 1'b0, 1'b0);
        check_beat("lb_b0", 0, 64'h100, 64'h8, 1'b0);

        do_access(0, OP_LOAD, F3_BU, 64'h103, 64'h0, 0, 64'h9A00_0000, 64'h0);
        check_resp("lbu", 3, 1, 64'h0000_009A, 1'b0, 1'b0);

        do_access(0, OP_STORE, F3_W, 64'h102, 64'hAABB_CCDD, 0, 64'h0, 64'h0);
        check_resp("sw_split", 5, 2, 64'h0, 1'b0, 1'b0);
        check_beat("sw_b0", 0, 64'h100, 64'hC, 1'b1);
        check("sw_b0_wdata", beat_wdata[0], 64'hCCDD_0000);
        check_beat("sw_b1", 1, 64'h104, 64'h3, 1'b1);
        check("sw_b1_wdata", beat_wdata[1], 64'h0000_AABB);

        do_access(0, OP_LOAD, F3_H, 64'h103, 64'h0, 0, 64'h3400_0000, 64'h0000_00F2);
        check_resp("lh_split", 5, 2, 64'hFFFF_F234, 1'b0, 1'b0);
        check_beat("lh_b0", 0, 64'h100, 64'h8, 1'b0);
        check_beat("lh_b1", 1, 64'h104, 64'h1, 1'b0);

        do_access(0, OP_STORE, F3_H, 64'h101, 64'h1234_5678, 0, 64'h0, 64'h0);
        check_resp("sh", 3, 1, 64'h0, 1'b0, 1'b0);
        check_beat("sh_b0", 0, 64'h100, 64'h6, 1'b1);
        check("sh_b0_wdata", beat_wdata[0], 64'h3456_7800);

        do_access(0, OP_LOAD, F3_HU, 64'h102, 64'h0, 0, 64'h8001_0000, 64'h0);
        check_resp("lhu", 3, 1, 64'h0000_8001, 1'b0, 1'b0);
        check_beat("lhu_b0", 0, 64'h100, 64'hC, 1'b0);

        do_access(0, OP_LOAD, F3_D, 64'h100, 64'h0, 0, 64'h0, 64'h0);
        check_resp("ld_on_rv32", 1, 0, 64'h0, 1'b0, 1'b1);
        do_access(0, OP_STORE, F3_BU, 64'h100, 64'h0, 0, 64'h0, 64'h0);
        check_resp("bad_store_f3", 1, 0, 64'h0, 1'b0, 1'b1);
        do_access(0, 7'b0110011, F3_W, 64'h100, 64'h0, 0, 64'h0, 64'h0);
        check_resp("bad_opcode", 1, 0, 64'h0, 1'b0, 1'b1);

        // Stray memory response while idle
        mem_resp_valid = 1'b1;
        mem_read_data  = 64'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        check("stray_no_resp", obs_resp_valid, 1'b0);
        check("stray_ready", obs_req_ready, 1'b1);

        // Reset while waiting for the memory response
        opcode    = OP_LOAD;
        funct3    = F3_W;
        address   = 64'h200;
        req_valid = 3'b001;
        #1;
        check("rw_ready", obs_req_ready, 1'b1);
        tick();
        req_valid     = 3'b000;
        mem_req_ready = 1'b1;
        check("rw_issue", obs_mem_req_valid, 1'b1);
        tick();
        mem_req_ready = 1'b0;
        check("rw_wait_idle_bus", obs_mem_req_valid, 1'b0);
        reset = 1'b1;
        #1;
        check("rw_rst_ready", obs_req_ready, 1'b0);
        check("rw_rst_resp", obs_resp_valid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("rw_idle_ready", obs_req_ready, 1'b1);
        mem_resp_valid = 1'b1;
        mem_read_data  = 64'h1234;
        tick();
        mem_resp_valid = 1'b0;
        check("rw_no_resp", obs_resp_valid, 1'b0);
        check("rw_still_idle", obs_req_ready, 1'b1);
        tick();
        check("rw_no_resp_later", obs_resp_valid, 1'b0);

        // 32-bit, boundary crossings fault
        do_access(1, OP_LOAD, F3_H, 64'h103, 64'h0, 0, 64'h0, 64'h0);
        check_resp("lh_nomis", 1, 0, 64'h0, 1'b1, 1'b0);
        do_access(1, OP_STORE, F3_W, 64'h102, 64'hAABB_CCDD, 0, 64'h0, 64'h0);
        check_resp("sw_nomis", 1, 0, 64'h0, 1'b1, 1'b0);
        do_access(1, OP_LOAD, F3_W, 64'h104, 64'h0, 0, 64'hCAFE_F00D, 64'h0);
        check_resp("lw_nomis", 3, 1, 64'hFFFF_FFFF_CAFE_F00D & 64'hFFFF_FFFF, 1'b0, 1'b0);
        check_beat("lw_nomis_b0", 0, 64'h104, 64'hF, 1'b0);

        // 64-bit
        do_access(2, OP_LOAD, F3_D, 64'h10, 64'h0, 4, 64'h0123_4567_89AB_CDEF, 64'h0);
        check_resp("ld64_stall", 7, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        check_beat("ld64_b0", 0, 64'h10, 64'hFF, 1'b0);

        do_access(2, OP_LOAD, F3_W, 64'h14, 64'h0, 0, 64'h89AB_CDEF_0000_0000, 64'h0);
        check_resp("lw64", 3, 1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0);
        check_beat("lw64_b0", 0, 64'h10, 64'hF0, 1'b0);

        do_access(2, OP_LOAD, F3_WU, 64'h14, 64'h0, 0, 64'h89AB_CDEF_0000_0000, 64'h0);
        check_resp("lwu64", 3, 1, 64'h0000_0000_89AB_CDEF, 1'b0, 1'b0);

        do_access(2, OP_STORE, F3_D, 64'h0C, 64'h1122_3344_5566_7788, 0, 64'h0, 64'h0);
        check_resp("sd64_split", 5, 2, 64'h0, 1'b0, 1'b0);
        check_beat("sd64_b0", 0, 64'h08, 64'hF0, 1'b1);
        check("sd64_b0_wdata", beat_wdata[0], 64'h5566_7788_0000_0000);
        check_beat("sd64_b1", 1, 64'h10, 64'h0F, 1'b1);
        check("sd64_b1_wdata", beat_wdata[1], 64'h0000_0000_1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_controller.md
LOAD_STORE_CONTROLLER -- requirements
Module: load_store_controller

Interface
REQ-001 Parameter XLEN, default 32, meaning: data/address width; legal values are 32 and 64.
REQ-002 Parameter SUPPORT_MISALIGNED, default 1, meaning: 1 = split boundary-crossing accesses into two beats; 0 = raise a fault.
REQ-003 Port CLK, input, 1, meaning: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, meaning: synchronous, active-high reset.
REQ-005 Port req_valid / req_ready, input / output, 1 / 1, meaning: core request handshake.
REQ-006 Port opcode, input, 7, meaning: LOAD 0000011 or STORE 0100011.
REQ-007 Port funct3, input, 3, meaning: access size and signedness.
REQ-008 Port address / store_data, input, XLEN each, meaning: byte address; store data, right-aligned.
REQ-009 Port resp_valid, output, 1, meaning: one-cycle completion pulse.
REQ-010 Port load_data, output, XLEN, meaning: extended load result.
REQ-011 Port misaligned_fault / access_fault, output, 1 each, meaning: fault flags qualified by resp_valid.
REQ-012 Port mem_req_valid / mem_req_ready, output / input, 1 / 1, meaning: memory request handshake.
REQ-013 Port mem_write, output, 1, meaning: 1 = store beat.
REQ-014 Port mem_address, output, XLEN, meaning: address aligned to XLEN/8 bytes.
REQ-015 Port mem_write_data / mem_byte_mask, output, XLEN / XLEN/8, meaning: lane-positioned store data; byte enables, bit i = byte lane i.
REQ-016 Port mem_resp_valid / mem_read_data, input, 1 / XLEN, meaning: beat completion (read data or write ack); read data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESPOND, plus a 1-bit beat index (0 or 1).
REQ-018 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready, opcode/funct3/address/store_data are registered and the FSM moves to ISSUE.
REQ-019 Legal funct3 values:
- loads: LB 000, LH 001, LW 010, LBU 100, LHU 101; with XLEN=64 also LD 011 and LWU 110.
- stores: SB 000, SH 001, SW 010; with XLEN=64 also SD 011.
REQ-020 Illegal opcode/funct3 SHALL go IDLE->RESPOND with access_fault=1, no memory beat.
REQ-021 Cross-boundary access (offset+size > XLEN/8) with SUPPORT_MISALIGNED=0 SHALL go IDLE->RESPOND with misaligned_fault=1, no memory beat.
REQ-022 ISSUE drives mem_req_valid=1 with stable mem_address/mask/data until mem_req_ready, then goes to WAIT.
REQ-023 WAIT on mem_resp_valid:
- if a second beat is needed and beat=0: beat<=1, return to ISSUE;
- otherwise: go to RESPOND.
REQ-024 Beat 0 SHALL use mem_address = address aligned down and mask = lanes offset..min(offset+size,XLEN/8)-1; beat 1 SHALL use aligned address + XLEN/8 and the remaining low lanes.
REQ-025 Store data SHALL be shifted left by offset*8 (beat 0); the bytes that overflow SHALL go to the low lanes of beat 1.
REQ-026 Load bytes SHALL be captured per beat and assembled little-endian, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN.
REQ-027 RESPOND SHALL assert resp_valid for exactly one cycle with load_data and fault flags held, then return to IDLE; load_data is 0 for stores and faults.
REQ-028 Latency: an aligned access with mem_req_ready=1 and a 1-cycle memory response SHALL raise resp_valid 3 cycles after acceptance; a split access SHALL take 5 cycles.
REQ-029 mem_resp_valid outside WAIT SHALL be ignored.
REQ-030 Only one request SHALL be outstanding; a new request is accepted no earlier than the cycle after RESPOND.

Reset
REQ-031 On reset the FSM SHALL go to IDLE with beat=0.
REQ-032 While reset is asserted, outputs SHALL be: req_ready=0, resp_valid=0, faults=0, mem_req_valid=0, mem_write=0, mask=0, load_data=0.
REQ-033 Reset mid-operation SHALL abandon the access with no response; a later mem_resp_valid is ignored per REQ-029.

Structure
REQ-034 Shared package lsu_pkg SHALL hold opcode constants, funct3 constants, the FSM state enum and the size-decode function.
REQ-035 Load byte extraction and extension SHALL be one sub-module, load_data_aligner (combinational, parametrised by XLEN).

Verification
REQ-036 XLEN=32, LW 0x100, memory returns 0x8000_00F0 -> one beat with mask 1111; resp_valid 3 cycles after acceptance; load_data 0x8000_00F0.
REQ-037 LB 0x103, memory returns 0x9A00_0000 -> mask 1000, load_data 0xFFFF_FF9A; LBU at the same address -> 0x0000_009A.
REQ-038 SUPPORT_MISALIGNED=1, SW 0x102 data 0xAABB_CCDD -> beat0 at 0x100, mask 1100, data 0xCCDD_0000; beat1 at 0x104, mask 0011, data 0x0000_AABB.
REQ-039 SUPPORT_MISALIGNED=0, LH 0x103 -> no mem_req_valid; resp_valid with misaligned_fault=1 one cycle after acceptance.
REQ-040 XLEN=64, LD 0x10 with mem_req_ready held low 4 cycles -> mem_req_valid and mem_address stay stable throughout; correct 64-bit result.
REQ-041 Reset asserted during WAIT, then mem_resp_valid pulses -> no resp_valid; FSM in IDLE; req_ready=1 after reset is released.
